control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Run-control and decode unit for the single-cycle 8-bit DataPath.
//  - Decodes the 19-bit instruction word into every DataPath control strobe.
//  - Gates execution with a run/step/halt FSM.
//  - Tracks call-stack depth to trap overflow/underflow.
//  - Counts retired instructions.
//  - Integration: the DataPath PC register loads only when pc_en=1; that input is added alongside this block.
// PARAMETERS
//  STACK_DEPTH  8   entries in the DataPath return-address stack; depth counter range 0..STACK_DEPTH
//  RET_W        16  width of the retired-instruction counter
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      synchronous, active-high reset
//  instruction    in   19     current instruction word from instruction memory
//  C, Z           in   1      carry/zero flags from DataPath
//  run            in   1      level: 1 = free-run
//  step           in   1      pulse: execute exactly one instruction from IDLE
//  mem_write, reg_write, push, pop, alu_use_carry, alu_in_mux, reg_B_mux   out 1  DataPath strobes
//  select_c, select_z, write_c, write_z   out  1       flag source selects / flag write enables
//  alu_op         out  3      ALU function
//  pc_mux         out  2      00 +1, 01 +1+imm8, 10 abs12, 11 stack
//  reg_write_mux  out  2      00 ALU, 01 shifter, 10 memory
//  pc_en          out  1      PC load enable
//  state          out  2      00 IDLE, 01 RUN, 10 STEP, 11 FAULT
//  fault          out  2      00 none, 01 stack overflow, 10 stack underflow, 11 illegal opcode
//  retired        out  RET_W  instructions executed since reset
// BEHAVIOUR
//  Decode (instr[18:16], sub = instr[15:14]):
//  - 00x R-ALU: alu_op=instr[16:14]; alu_in_mux=0; reg_write=1; write_c=write_z=1.
//  - 01x I-ALU: same as R-ALU but alu_in_mux=1.
//  - alu_use_carry=1 only for alu_op 001 (ADC) and 011 (SBC).
//  - 110 shift: reg_write_mux=01; select_c=select_z=1; write_c=write_z=1; reg_write=1.
//  - 100 memory, sub 00 LW: alu_op=000, alu_in_mux=1, reg_write_mux=10, reg_write=1.
//  - 100 memory, sub 01 SW: alu_op=000, alu_in_mux=1, reg_B_mux=1, mem_write=1.
//  - 100 memory, sub 1x: illegal.
//  - 101 branch, sub 00 BZ / 01 BNZ / 10 BC / 11 BNC: pc_mux=01 if condition true, else 00; no writes.
//  - 111 jump, sub 00 JMP: pc_mux=10.
//  - 111 jump, sub 01 JSR: pc_mux=10, push=1.
//  - 111 jump, sub 10 RET: pc_mux=11, pop=1.
//  - 111 jump, sub 11 HALT: pc_en=0, no writes.
//  - Default for all unlisted strobes: 0.
//  FSM, registered, reset -> IDLE:
//  - IDLE: if step=1 -> STEP; else if run=1 -> RUN; otherwise stay IDLE.
//  - RUN: HALT -> IDLE; trap -> FAULT; run=0 -> IDLE; otherwise stay RUN.
//  - STEP: always exits after one cycle, to FAULT on trap, else IDLE.
//  - FAULT: sticky until reset; run and step are ignored.
//  Gating:
//  - An instruction executes only in RUN or STEP; all strobes are combinational decode AND'ed with that.
//  - In IDLE/FAULT, and on the HALT or trap cycle: pc_en and every write/push/pop strobe = 0; mux selects don't-care.
//  Stack depth counter:
//  - depth increments on a committed push and decrements on a committed pop.
//  - JSR with depth==STACK_DEPTH -> trap 01.
//  - RET with depth==0 -> trap 10.
//  - Illegal opcode -> trap 11.
//  - On any trap: nothing commits, fault is latched at the edge, and state -> FAULT.
//  retired:
//  - +1 on each executed cycle, including HALT; a trap cycle is not counted.
//  - Wraps at 2^RET_W.
//  Reset, synchronous, takes priority over all else, including mid-STEP:
//  - state=IDLE, fault=0, depth=0, retired=0.
//  - All strobes 0, including pc_en.
//  Latency:
//  - Decode to strobes: 0 cycles.
//  - run/step to first execution: 1 cycle (the state register must update first).
// STRUCTURE
//  - Package cs_pkg: opcode/subop localparams, alu_op codes (ADD=000, ADC=001, SBC=011), state and fault encodings.
//  - Sub-module instr_decoder: purely combinational, instruction + C/Z -> ungated strobe bundle + illegal flag.
//  - control_sequencer holds the FSM, depth counter, retired counter and output gating.
// TESTING
//  1. reset=1 for 2 cycles with run=1 -> state=00, all strobes 0; run held -> state=01 one cycle after reset drops.
//  2. IDLE, one-cycle step pulse over I-ALU ADDI (19'b01_000_001_010_00000101) -> one cycle with reg_write=1, alu_in_mux=1, pc_en=1, retired=1; then IDLE with pc_en=0.
//  3. RUN: BZ with Z=1 -> pc_mux=01; BZ with Z=0 -> pc_mux=00; ADC -> alu_use_carry=1; SW -> mem_write=1 and reg_B_mux=1.
//  4. RUN, 8 JSRs then a 9th (STACK_DEPTH=8) -> 9th cycle push=0 and pc_en=0; fault=01, state=11; run/step then ignored.
//  5. After reset, RET at depth 0 -> fault=10; opcode 100 sub 10 -> fault=11; retired unchanged on the trap cycle.
//  6. RUN, HALT -> pc_en=0 that cycle and state=00 next; also assert reset during a STEP cycle -> IDLE with retired=0.

Source files
------------

// File: rtl/cs_pkg.sv
// Shared encodings for the DataPath control sequencer: opcodes, sub-ops,
// ALU codes, FSM state / fault encodings and the decoded strobe bundle.
package cs_pkg;

  localparam logic [2:0] OP_MEM    = 3'b100;
  localparam logic [2:0] OP_BRANCH = 3'b101;
  localparam logic [2:0] OP_SHIFT  = 3'b110;
  localparam logic [2:0] OP_JUMP   = 3'b111;

  localparam logic [1:0] SUB_LW   = 2'b00;
  localparam logic [1:0] SUB_SW   = 2'b01;
  localparam logic [1:0] SUB_BZ   = 2'b00;
  localparam logic [1:0] SUB_BNZ  = 2'b01;
  localparam logic [1:0] SUB_BC   = 2'b10;
  localparam logic [1:0] SUB_BNC  = 2'b11;
  localparam logic [1:0] SUB_JMP  = 2'b00;
  localparam logic [1:0] SUB_JSR  = 2'b01;
  localparam logic [1:0] SUB_RET  = 2'b10;
  localparam logic [1:0] SUB_HALT = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_ADC = 3'b001;
  localparam logic [2:0] ALU_SBC = 3'b011;

  localparam logic [1:0] PC_INC   = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_ABS   = 2'b10;
  localparam logic [1:0] PC_STACK = 2'b11;

  localparam logic [1:0] WB_SHIFT = 2'b01;
  localparam logic [1:0] WB_MEM   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    FLT_NONE      = 2'b00,
    FLT_OVERFLOW  = 2'b01,
    FLT_UNDERFLOW = 2'b10,
    FLT_ILLEGAL   = 2'b11
  } fault_t;

  typedef struct packed {
    logic       mem_write;
    logic       reg_write;
    logic       push;
    logic       pop;
    logic       alu_use_carry;
    logic       alu_in_mux;
    logic       reg_b_mux;
    logic       select_c;
    logic       select_z;
    logic       write_c;
    logic       write_z;
    logic [2:0] alu_op;
    logic [1:0] pc_mux;
    logic [1:0] reg_write_mux;
  } strobes_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational decode of the 19-bit instruction word (plus C/Z for
// branches) into the ungated DataPath strobe bundle, HALT and illegal flags.
module instr_decoder
  import cs_pkg::*;
(
  input  logic [18:0] instruction,
  input  logic        c_flag,
  input  logic        z_flag,
  output strobes_t    strobes,
  output logic        halt,
  output logic        illegal
);

  logic [2:0] op;
  logic [1:0] sub;
  logic       taken;
  logic       unused_operand;

  assign op  = instruction[18:16];
  assign sub = instruction[15:14];

  // Register/immediate fields are consumed by the DataPath, not here.
  assign unused_operand = ^instruction[13:0];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    strobes = '0;
    halt    = 1'b0;
    illegal = 1'b0;
    taken   = 1'b0;
    case (op)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        strobes.alu_op        = instruction[16:14];
        strobes.alu_in_mux    = op[1];
        strobes.reg_write     = 1'b1;
        strobes.write_c       = 1'b1;
        strobes.write_z       = 1'b1;
        strobes.alu_use_carry = (instruction[16:14] == ALU_ADC) ||
                                (instruction[16:14] == ALU_SBC);
      end
      OP_SHIFT: begin
        strobes.reg_write_mux = WB_SHIFT;
        strobes.select_c      = 1'b1;
        strobes.select_z      = 1'b1;
        strobes.write_c       = 1'b1;
        strobes.write_z       = 1'b1;
        strobes.reg_write     = 1'b1;
      end
      OP_MEM: begin
        strobes.alu_op     = ALU_ADD;
        strobes.alu_in_mux = 1'b1;
        case (sub)
          SUB_LW: begin
            strobes.reg_write_mux = WB_MEM;
            strobes.reg_write     = 1'b1;
          end
          SUB_SW: begin
            strobes.reg_b_mux = 1'b1;
            strobes.mem_write = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        case (sub)
          SUB_BZ:  taken = z_flag;
          SUB_BNZ: taken = !z_flag;
          SUB_BC:  taken = c_flag;
          SUB_BNC: taken = !c_flag;
          default: taken = 1'b0;
        endcase
        strobes.pc_mux = taken ? PC_REL : PC_INC;
      end
      OP_JUMP: begin
        case (sub)
          SUB_JMP: strobes.pc_mux = PC_ABS;
          SUB_JSR: begin
            strobes.pc_mux = PC_ABS;
            strobes.push   = 1'b1;
          end
          SUB_RET: begin
            strobes.pc_mux = PC_STACK;
            strobes.pop    = 1'b1;
          end
          default: halt = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Run/step/halt FSM, call-stack depth trap and retired-instruction counter
// around the combinational instruction decoder, with output gating.
module control_sequencer
  import cs_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int RET_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [18:0]      instruction,
  input  logic             C,
  input  logic             Z,
  input  logic             run,
  input  logic             step,
  output logic             mem_write,
  output logic             reg_write,
  output logic             push,
  output logic             pop,
  output logic             alu_use_carry,
  output logic             alu_in_mux,
  output logic             reg_B_mux,
  output logic             select_c,
  output logic             select_z,
  output logic             write_c,
  output logic             write_z,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_mux,
  output logic [1:0]       reg_write_mux,
  output logic             pc_en,
  output logic [1:0]       state,
  output logic [1:0]       fault,
  output logic [RET_W-1:0] retired
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  strobes_t           dec;
  logic               halt;
  logic               illegal;
  state_t             state_q;
  fault_t             fault_q;
  fault_t             trap_code;
  logic [DEPTH_W-1:0] depth;
  logic               exec;
  logic               trap_ovf;
  logic               trap_unf;
  logic               trap;
  logic               commit;
  logic               retire;

  instr_decoder u_decoder (
    .instruction (instruction),
    .c_flag      (C),
    .z_flag      (Z),
    .strobes     (dec),
    .halt        (halt),
    .illegal     (illegal)
  );

  // Reset also masks the outputs so a STEP cycle hit by reset never writes.
  assign exec     = !reset && (state_q == ST_RUN || state_q == ST_STEP);
  assign trap_ovf = dec.push && (depth == DEPTH_W'(STACK_DEPTH));
  assign trap_unf = dec.pop && (depth == '0);
  assign trap     = illegal || trap_ovf || trap_unf;
  assign commit   = exec && !trap && !halt;
  assign retire   = exec && !trap;

  assign trap_code = illegal  ? FLT_ILLEGAL  :
                     trap_ovf ? FLT_OVERFLOW : FLT_UNDERFLOW;

  assign mem_write     = commit && dec.mem_write;
  assign reg_write     = commit && dec.reg_write;
  assign push          = commit && dec.push;
  assign pop           = commit && dec.pop;
  assign write_c       = commit && dec.write_c;
  assign write_z       = commit && dec.write_z;
  assign pc_en         = commit;
  assign alu_use_carry = exec && dec.alu_use_carry;
  assign alu_in_mux    = exec && dec.alu_in_mux;
  assign reg_B_mux     = exec && dec.reg_b_mux;
  assign select_c      = exec && dec.select_c;
  assign select_z      = exec && dec.select_z;
  assign alu_op        = exec ? dec.alu_op        : 3'b000;
  assign pc_mux        = exec ? dec.pc_mux        : 2'b00;
  assign reg_write_mux = exec ? dec.reg_write_mux : 2'b00;

  assign state = state_q;
  assign fault = fault_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fault_q <= FLT_NONE;
      depth   <= '0;
      retired <= '0;
    end else begin
      if (push)
        depth <= depth + 1'b1;
      else if (pop)
        depth <= depth - 1'b1;

      if (retire)
        retired <= retired + 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (step)
            state_q <= ST_STEP;
          else if (run)
            state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (halt) begin
            state_q <= ST_IDLE;
          end else if (trap) begin
            state_q <= ST_FAULT;
            fault_q <= trap_code;
          end else if (!run) begin
            state_q <= ST_IDLE;
          end
        end
        ST_STEP: begin
          if (trap) begin
            state_q <= ST_FAULT;
            fault_q <= trap_code;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_FAULT;
      endcase
    end
  end

endmodule
